// File: rtl/lvds_lcd_packer.sv
// LCD video timing generator that packs RGB888 plus sync/DE into four 7-bit LVDS data-lane words and a clock-lane word.
// Optional build macro LVDS_TEST_PATTERN_EN adds TP_SEL and an 8-bar color pattern source.
module lvds_lcd_packer #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 160,
  parameter int H_SYNC   = 20,
  parameter int H_BP     = 140,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 12,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 20,
  parameter int SYNC_POL = 0
) (
  input  logic        CLKDIV,
  input  logic        RST_N,
  input  logic        EN,
  input  logic [23:0] PIX_DATA,
  input  logic        PIX_VALID,
  output logic        PIX_READY,
  output logic        FRAME_START,
  output logic [6:0]  LANE0,
  output logic [6:0]  LANE1,
  output logic [6:0]  LANE2,
  output logic [6:0]  LANE3,
  output logic [6:0]  LANE_CLK,
  output logic        OE,
  output logic        UNDERFLOW,
  input  logic        UF_CLR
`ifdef LVDS_TEST_PATTERN_EN
  ,
  input  logic        TP_SEL
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = ($clog2(H_TOTAL) > 11) ? $clog2(H_TOTAL) : 11;
  localparam int VW = ($clog2(V_TOTAL) > 11) ? $clog2(V_TOTAL) : 11;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_E  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_E  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          SYNC_INV = (SYNC_POL == 0);
  localparam logic [6:0]    CLK_WORD = 7'b1100011;

  // S_START is the single lead-in cycle after EN rises; it carries FRAME_START
  // so that the first PIX_READY of the frame lands exactly one cycle later.
  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;
  state_t state;

  logic [HW-1:0] h, h_nxt;
  logic [VW-1:0] v, v_nxt;
  logic [27:0]   lanes, blank_word;
  logic [23:0]   rgb, tp_rgb;
  logic          de_cur, starve, tp_on;

  function automatic logic de_at(input logic [HW-1:0] hh, input logic [VW-1:0] vv);
    return (hh < H_ACT_E) && (vv < V_ACT_E);
  endfunction

  function automatic logic hs_lane(input logic [HW-1:0] hh);
    return ((hh >= HS_BEG) && (hh < HS_END)) ^ SYNC_INV;
  endfunction

  function automatic logic vs_lane(input logic [VW-1:0] vv);
    return ((vv >= VS_BEG) && (vv < VS_END)) ^ SYNC_INV;
  endfunction

  // Returns {LANE3, LANE2, LANE1, LANE0}.
  function automatic logic [27:0] pack(input logic [23:0] px, input logic hs,
                                       input logic vs, input logic de);
    logic [7:0] r, g, b;
    r = px[23:16];
    g = px[15:8];
    b = px[7:0];
    return {{1'b0, b[7:6], g[7:6], r[7:6]},
            {de, vs, hs, b[5:2]},
            {b[1:0], g[5:1]},
            {g[0], r[5:0]}};
  endfunction

`ifdef LVDS_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  // Bar order white,yellow,cyan,green,magenta,red,blue,black falls out of the
  // bar index bits: R = ~idx[1], G = ~idx[2], B = ~idx[0].
  function automatic logic [23:0] bar_rgb(input logic [HW-1:0] hh);
    logic [HW-1:0] idx;
    idx = hh / HW'(BAR_W);
    if (idx > HW'(7)) idx = HW'(7);
    return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
  endfunction

  assign tp_on  = TP_SEL;
  assign tp_rgb = bar_rgb(h);
`else
  assign tp_on  = 1'b0;
  assign tp_rgb = '0;
`endif

  always_comb begin
    h_nxt = (h == H_LAST) ? '0 : h + HW'(1);
    v_nxt = v;
    if (h == H_LAST) v_nxt = (v == V_LAST) ? '0 : v + VW'(1);
  end

  assign de_cur     = (state == S_RUN) && de_at(h, v);
  assign starve     = EN && de_cur && !tp_on && !PIX_VALID;
  assign blank_word = pack(24'h0, SYNC_INV, SYNC_INV, 1'b0);

  always_comb begin
    rgb = '0;
    if (de_cur) begin
      if (tp_on)          rgb = tp_rgb;
      else if (PIX_VALID) rgb = PIX_DATA;
    end
  end

  // h/v hold the position whose PIX_READY is currently presented; the lane
  // word for that position is captured on the same edge that consumes the pixel.
  always_ff @(posedge CLKDIV or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      h           <= '0;
      v           <= '0;
      PIX_READY   <= 1'b0;
      FRAME_START <= 1'b0;
      lanes       <= '0;
      LANE_CLK    <= '0;
      OE          <= 1'b0;
      UNDERFLOW   <= 1'b0;
    end else begin
      UNDERFLOW <= starve || (UNDERFLOW && !UF_CLR);
      if (!EN) begin
        state       <= S_IDLE;
        h           <= '0;
        v           <= '0;
        PIX_READY   <= 1'b0;
        FRAME_START <= 1'b0;
        lanes       <= blank_word;
        LANE_CLK    <= '0;
        OE          <= 1'b0;
      end else begin
        OE       <= 1'b1;
        LANE_CLK <= CLK_WORD;
        case (state)
          S_IDLE: begin
            state       <= S_START;
            FRAME_START <= 1'b1;
            PIX_READY   <= 1'b0;
            lanes       <= blank_word;
          end
          S_START: begin
            state       <= S_RUN;
            FRAME_START <= 1'b0;
            PIX_READY   <= de_at('0, '0) && !tp_on;
            lanes       <= blank_word;
          end
          S_RUN: begin
            h           <= h_nxt;
            v           <= v_nxt;
            PIX_READY   <= de_at(h_nxt, v_nxt) && !tp_on;
            FRAME_START <= (h_nxt == H_LAST) && (v_nxt == V_LAST);
            lanes       <= pack(rgb, hs_lane(h), vs_lane(v), de_cur);
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign LANE0 = lanes[6:0];
  assign LANE1 = lanes[13:7];
  assign LANE2 = lanes[20:14];
  assign LANE3 = lanes[27:21];

endmodule

// File: tb/tb_lvds_lcd_packer.sv
// Scoreboard bench for lvds_lcd_packer: a timeline-based reference model predicts every output cycle,
// a negedge monitor compares, plus directed checks on frame counts, underflow, EN drop and async reset.
module tb_lvds_lcd_packer;

  localparam int H_A = 8, H_F = 2, H_S = 2, H_B = 2;
  localparam int V_A = 4, V_F = 1, V_S = 1, V_B = 1;
  localparam int SPOL = 0;
  localparam int H_T = H_A + H_F + H_S + H_B;
  localparam int V_T = V_A + V_F + V_S + V_B;
  localparam bit POL = (SPOL != 0);
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        pix_valid = 1'b0;
  logic        uf_clr = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_ready, frame_start, oe, underflow;
  logic [6:0]  lane0, lane1, lane2, lane3, lane_clk;
  logic        tp_now;
`ifdef LVDS_TEST_PATTERN_EN
  logic        tp_sel = 1'b0;
  assign tp_now = tp_sel;
`else
  assign tp_now = 1'b0;
`endif

  lvds_lcd_packer #(
    .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B), .SYNC_POL(SPOL)
  ) dut (
    .CLKDIV(clk), .RST_N(rst_n), .EN(en), .PIX_DATA(pix_data), .PIX_VALID(pix_valid),
    .PIX_READY(pix_ready), .FRAME_START(frame_start),
    .LANE0(lane0), .LANE1(lane1), .LANE2(lane2), .LANE3(lane3), .LANE_CLK(lane_clk),
    .OE(oe), .UNDERFLOW(underflow), .UF_CLR(uf_clr)
`ifdef LVDS_TEST_PATTERN_EN
    , .TP_SEL(tp_sel)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [38:0] exp_q [$];
  logic [38:0] act;
  assign act = {pix_ready, frame_start, oe, underflow, lane_clk, lane3, lane2, lane1, lane0};

  // Spec bit tables written out per lane bit.
  function automatic logic [27:0] lanes_of(logic [23:0] px, logic hs, logic vs, logic de);
    logic [7:0] r, g, b;
    logic [6:0] l0, l1, l2, l3;
    r = px[23:16]; g = px[15:8]; b = px[7:0];
    for (int i = 0; i < 6; i++) l0[i] = r[i];
    l0[6] = g[0];
    for (int i = 0; i < 5; i++) l1[i] = g[i+1];
    l1[5] = b[0]; l1[6] = b[1];
    for (int i = 0; i < 4; i++) l2[i] = b[i+2];
    l2[4] = hs; l2[5] = vs; l2[6] = de;
    l3[0] = r[6]; l3[1] = r[7]; l3[2] = g[6]; l3[3] = g[7]; l3[4] = b[6]; l3[5] = b[7]; l3[6] = 1'b0;
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [23:0] rgb_of(logic [6:0] l0, logic [6:0] l1, logic [6:0] l2, logic [6:0] l3);
    logic [7:0] r, g, b;
    for (int i = 0; i < 6; i++) r[i] = l0[i];
    r[6] = l3[0]; r[7] = l3[1];
    g[0] = l0[6];
    for (int i = 0; i < 5; i++) g[i+1] = l1[i];
    g[6] = l3[2]; g[7] = l3[3];
    b[0] = l1[5]; b[1] = l1[6];
    for (int i = 0; i < 4; i++) b[i+2] = l2[i];
    b[6] = l3[4]; b[7] = l3[5];
    return {r, g, b};
  endfunction

  function automatic logic sync_lane(logic active);
    return active ? POL : !POL;
  endfunction

  // Reference model: run_t counts cycles since EN was first sampled high;
  // cycle 0 is the lead-in, cycle t>=1 presents raster position t-1.
  int   run_t = -1;
  logic uf_m = 1'b0;

  always @(posedge clk) begin
    logic [27:0] ln;
    logic [23:0] px;
    logic [6:0]  lc;
    logic        rd, fs, o, st, de;
    int          p, x, y;
    if (!rst_n) begin
      run_t = -1;
      uf_m  = 1'b0;
      exp_q.push_back('0);
    end else begin
      ln = lanes_of(24'h0, !POL, !POL, 1'b0);
      rd = 1'b0; fs = 1'b0; o = 1'b0; st = 1'b0; lc = '0;
      if (!en) begin
        run_t = -1;
      end else begin
        o  = 1'b1;
        lc = 7'b1100011;
        if (run_t >= 1) begin
          p  = run_t - 1;
          x  = p % H_T;
          y  = (p / H_T) % V_T;
          de = (x < H_A) && (y < V_A);
          if (!de)          px = 24'h0;
          else if (tp_now)  px = BARS[x];
          else if (pix_valid) px = pix_data;
          else              px = 24'h0;
          ln = lanes_of(px, sync_lane(x >= H_A + H_F && x < H_A + H_F + H_S),
                        sync_lane(y >= V_A + V_F && y < V_A + V_F + V_S), de);
          st = de && !tp_now && !pix_valid;
        end
        if (run_t < 0) begin
          run_t = 0;
          fs    = 1'b1;
        end else begin
          run_t = run_t + 1;
          p  = run_t - 1;
          x  = p % H_T;
          y  = (p / H_T) % V_T;
          rd = (x < H_A) && (y < V_A) && !tp_now;
          fs = (x == H_T - 1) && (y == V_T - 1);
        end
      end
      uf_m = st || (uf_m && !uf_clr);
      exp_q.push_back({rd, fs, o, uf_m, lc, ln});
    end
  end

  always @(negedge clk) begin
    logic [38:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst_n) e = '0;
      n_chk++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got %h expected %h", $time, act, e);
      end
    end
  end

  task automatic check(input string name, input logic [38:0] got, input logic [38:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fs_n, rd_n, de_n, hs_n, vs_n;
    bit found;
    fs_n = 0; rd_n = 0; de_n = 0; hs_n = 0; vs_n = 0;

    repeat (3) step();
    check("reset_state", act, 39'(0));
    rst_n = 1'b1;
    step(); step();
    check("idle_oe", 39'(oe), 39'(0));
    check("idle_lane2_blank", 39'(lane2), 39'(7'b0110000));

    // Three full frames of continuous valid data.
    en = 1'b1; pix_valid = 1'b1; pix_data = 24'h000100;
    for (int i = 0; i < 3 * H_T * V_T; i++) begin
      step();
      fs_n += int'(frame_start);
      rd_n += int'(pix_ready);
      de_n += int'(lane2[6]);
      hs_n += int'(!lane2[4]);
      vs_n += int'(!lane2[5]);
      if (i == 21) begin
        check("pix_123456_lane0", 39'(lane0), 39'(7'b0010010));
        check("pix_123456_lane3_r67", 39'(lane3[1:0]), 39'(2'b00));
        check("pix_123456_rgb", 39'(rgb_of(lane0, lane1, lane2, lane3)), 39'(24'h123456));
      end
      if (i == 20) pix_data = 24'h123456;
      else         pix_data = pix_data + 24'd1;
    end
    check("frame_start_count", 39'(fs_n), 39'(3));
    check("pix_ready_count", 39'(rd_n), 39'(3 * H_A * V_A));
    check("lane_de_count", 39'(de_n), 39'(3 * H_A * V_A));
    check("hs_low_count", 39'(hs_n), 39'(3 * V_T * H_S));
    check("vs_low_count", 39'(vs_n), 39'(3 * V_S * H_T));

    // Starve one active cycle.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (pix_ready) found = 1'b1;
    end
    check("wait_ready", 39'(found), 39'(1));
    pix_valid = 1'b0;
    step();
    pix_valid = 1'b1;
    check("starve_black", 39'({lane3, lane2[3:0], lane1, lane0}), 39'(0));
    check("starve_de", 39'(lane2[6]), 39'(1));
    check("uf_set", 39'(underflow), 39'(1));
    repeat (3) step();
    check("uf_sticky", 39'(underflow), 39'(1));
    uf_clr = 1'b1;
    step();
    uf_clr = 1'b0;
    check("uf_clr", 39'(underflow), 39'(0));

    // Drop EN at h=5, then restart.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (frame_start) found = 1'b1;
    end
    check("wait_frame_start", 39'(found), 39'(1));
    repeat (6) step();
    en = 1'b0;
    step();
    check("en_drop_oe", 39'(oe), 39'(0));
    check("en_drop_lane_clk", 39'(lane_clk), 39'(0));
    check("en_drop_ready", 39'(pix_ready), 39'(0));
    check("en_drop_lane2", 39'(lane2), 39'(7'b0110000));
    en = 1'b1;
    step();
    check("restart_frame_start", 39'(frame_start), 39'(1));
    check("restart_oe", 39'(oe), 39'(1));
    step();
    check("restart_ready_h0", 39'(pix_ready), 39'(1));
    step();
    check("restart_de_h0", 39'(lane2[6]), 39'(1));

`ifdef LVDS_TEST_PATTERN_EN
    en = 1'b0;
    step();
    tp_sel = 1'b1; en = 1'b1;
    step();
    step();
    for (int j = 0; j < 8; j++) begin
      step();
      check("tp_ready_low", 39'(pix_ready), 39'(0));
      if (j == 0 || j == 2 || j == 7)
        check($sformatf("tp_pixel%0d", j), 39'(rgb_of(lane0, lane1, lane2, lane3)), 39'(BARS[j]));
    end
    tp_sel = 1'b0;
`endif

    // Randomized run with one asynchronous reset in the middle.
    for (int k = 0; k < 1500; k++) begin
      en        = ($urandom_range(0, 149) != 0);
      pix_valid = ($urandom_range(0, 9) != 0);
      pix_data  = 24'($urandom());
      uf_clr    = ($urandom_range(0, 29) == 0);
`ifdef LVDS_TEST_PATTERN_EN
      tp_sel    = ($urandom_range(0, 3) == 0);
`endif
      step();
      if (k == 700) begin
        #2 rst_n = 1'b0;
        #1 check("async_reset", act, 39'(0));
        step();
        rst_n = 1'b1;
      end
    end

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
